// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the LC-3 SRAM memory sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD     = 2'd1,
    ST_WR     = 2'd2,
    ST_WR_REC = 2'd3
  } mem_seq_state_t;

  // Memory-mapped I/O word, zero-extended to the SRAM address width at use.
  localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

  localparam int DEF_RD_WAIT = 1;
  localparam int DEF_WR_WAIT = 1;

endpackage

// File: rtl/mem_tristate.sv
// Bidirectional buffer for the SRAM data bus; drives only while drive_en is high.
module mem_tristate #(
  parameter int W = 16
) (
  inout  wire  [W-1:0] dq,
  input  logic [W-1:0] data,
  input  logic         drive_en,
  output logic [W-1:0] rd_value
);

  assign dq       = drive_en ? data : {W{1'bz}};
  assign rd_value = dq;

endmodule

// File: rtl/mem_sequencer.sv
// Single-word SRAM read/write sequencer with programmable strobe wait cycles.
// Optional memory-mapped switches/hex display at MMIO_ADDR when MMIO_EN is defined.
//
// state   | meaning
// IDLE    | strobes high, bus released, requests sampled
// RD      | CE/OE low, bus released, data captured when wcnt reaches 0
// WR      | CE/WE low, latched data driven onto the bus
// WR_REC  | WE high, CE low, data still driven for one hold cycle
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Rd_req,
  input  logic              Wr_req,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Wr_data,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Done,
  output logic              Busy,
  output logic [ADDR_W-1:0] Mem_ADDR,
  inout  wire  [DATA_W-1:0] Mem_DQ,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
`ifdef MMIO_EN
  ,
  input  logic [DATA_W-1:0] Switches,
  output logic [DATA_W-1:0] Hex_out
`endif
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_RD     = ST_RD;
  localparam logic [1:0] S_WR     = ST_WR;
  localparam logic [1:0] S_WR_REC = ST_WR_REC;

  logic [1:0]        state;
  logic [2:0]        wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done_q;
  logic [DATA_W-1:0] dq_in;
  logic              drive_en;
  logic              mmio_hit;
  logic [DATA_W-1:0] mmio_rd;

`ifdef MMIO_EN
  assign mmio_hit = (Addr == ADDR_W'(MMIO_ADDR));
  assign mmio_rd  = Switches;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Hex_out <= '0;
    end else if (state == S_IDLE && Wr_req && mmio_hit) begin
      Hex_out <= Wr_data;
    end
  end
`else
  assign mmio_hit = 1'b0;
  assign mmio_rd  = '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // Write has priority; a simultaneous read is dropped.
          if (Wr_req) begin
            addr_q  <= Addr;
            wdata_q <= Wr_data;
            if (mmio_hit) begin
              done_q <= 1'b1;
            end else begin
              state <= S_WR;
              wcnt  <= 3'(WR_WAIT);
            end
          end else if (Rd_req) begin
            addr_q  <= Addr;
            wdata_q <= Wr_data;
            if (mmio_hit) begin
              rd_data_q <= mmio_rd;
              done_q    <= 1'b1;
            end else begin
              state <= S_RD;
              wcnt  <= 3'(RD_WAIT);
            end
          end
        end
        S_RD: begin
          if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else begin
            rd_data_q <= dq_in;
            done_q    <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_WR: begin
          if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else begin
            state <= S_WR_REC;
          end
        end
        default: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so reset releases them at once.
  assign Mem_CE   = (state == S_IDLE);
  assign Mem_UB   = (state == S_IDLE);
  assign Mem_LB   = (state == S_IDLE);
  assign Mem_OE   = (state != S_RD);
  assign Mem_WE   = (state != S_WR);
  assign drive_en = (state == S_WR) || (state == S_WR_REC);

  assign Busy     = (state != S_IDLE);
  assign Done     = done_q;
  assign Rd_data  = rd_data_q;
  assign Mem_ADDR = addr_q;

  mem_tristate #(
    .W(DATA_W)
  ) u_dq (
    .dq      (Mem_DQ),
    .data    (wdata_q),
    .drive_en(drive_en),
    .rd_value(dq_in)
  );

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Bus-side memory sequencer between the LC-3 datapath/control unit and the off-chip 16-bit asynchronous SRAM. It accepts single-word read/write requests from the control unit (MAR address, MDR data), sequences the active-low SRAM strobes with a configurable number of wait cycles, returns read data registered for loading into MDR, and signals completion with a one-cycle `Done` pulse. The control unit therefore waits on `Done` instead of stepping through fixed-length memory states.

## Interface
- `ADDR_W`, 20: SRAM address width.
- `DATA_W`, 16: data word width.
- `RD_WAIT`, 1: extra OE-low cycles per read. The range is 0–7.
- `WR_WAIT`, 1: extra WE-low cycles per write. The range is 0–7.

- `Clk` in 1: the single clock; everything is sampled on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Rd_req` in 1: read request. It is sampled only in IDLE.
- `Wr_req` in 1: write request. It is sampled only in IDLE.
- `Addr` in ADDR_W: word address (the MAR value).
- `Wr_data` in DATA_W: write data (the MDR value).
- `Rd_data` out DATA_W: registered read data.
- `Done` out 1: one-cycle completion pulse.
- `Busy` out 1: high whenever the state is not IDLE.
- `Mem_ADDR` out ADDR_W: SRAM address, driven from the internal address register.
- `Mem_DQ` inout DATA_W: SRAM data bus.
- `Mem_CE`, `Mem_UB`, `Mem_LB`, `Mem_OE`, `Mem_WE` out 1 each: active-low SRAM strobes.
- `Switches` in DATA_W: board switches. Present only when MMIO is compiled in.
- `Hex_out` out DATA_W: hex display register. Present only when MMIO is compiled in.

## Operation
- States are IDLE, RD, WR and WR_REC. A 3-bit down-counter `wcnt` times the RD and WR states.
- **Accept (IDLE):**
  - `Addr` and `Wr_data` are latched into internal registers on acceptance. Input changes while `Busy` is high are ignored.
  - If both `Wr_req` and `Rd_req` are high, the write wins. The read is dropped, and the requester must re-issue it after `Done`.
  - `Wr_req`: go to WR with `wcnt = WR_WAIT`.
  - `Rd_req`: go to RD with `wcnt = RD_WAIT`.
- **RD:**
  - Signals: `Mem_CE`, `Mem_UB`, `Mem_LB` and `Mem_OE` are low; `Mem_WE` is high; `Mem_DQ` is tri-stated.
  - While `wcnt != 0`: decrement `wcnt`.
  - When `wcnt == 0`: capture `Rd_data <= Mem_DQ`, pulse `Done`, and go to IDLE.
- **WR:**
  - Signals: `Mem_CE`, `Mem_UB`, `Mem_LB` and `Mem_WE` are low; `Mem_OE` is high; `Mem_DQ` drives the latched data.
  - When `wcnt == 0`: go to WR_REC.
- **WR_REC:**
  - Signals: `Mem_WE` is high; `Mem_CE` is low; `Mem_DQ` is still driven, giving one cycle of data hold.
  - Then: pulse `Done` and go to IDLE.
- **IDLE signals:** all strobes are high and `Mem_DQ` is tri-stated.
- **Done and back-to-back requests:** `Done` is registered, so it is high in the first IDLE cycle. A new request may be accepted in that same cycle.
- **Rd_data hold:** `Rd_data` holds its value until the next read completes.

## Timing
- Request sampled at cycle n (state IDLE):
  - Read: `Done` is high at cycle n+RD_WAIT+2. With the defaults, OE is low in cycles n+1 and n+2, and `Done` and valid `Rd_data` appear at n+3.
  - Write: WE is low for WR_WAIT+1 cycles and the hold cycle follows. `Done` is at n+WR_WAIT+3.
  - MMIO access: `Done` is at n+1. No strobes are asserted.
- **Reset values (asynchronous; `Reset_n` low at any time, including mid-access):**
  - State is IDLE.
  - All strobes go high immediately.
  - `Mem_DQ` is tri-stated.
  - `Rd_data`, `Hex_out`, `Mem_ADDR` and `wcnt` are 0.
  - `Done` and `Busy` are 0.
  - An in-flight access is abandoned and no `Done` is produced.
- **`RD_WAIT`/`WR_WAIT` = 0:** a single strobe cycle is legal.

## Configuration
- `MMIO_EN`, defined:
  - Address `MMIO_ADDR` (all ones, 0xFFFF zero-extended to ADDR_W) is decoded in IDLE.
  - A read at this address registers `Switches` into `Rd_data`.
  - A write at this address loads `Hex_out`.
  - Both complete in one cycle with no SRAM strobes.
  - The `Switches` and `Hex_out` ports exist.
- `MMIO_EN` undefined: that address is ordinary SRAM and the ports are removed.

## Structure
- The package `mem_seq_pkg` holds:
  - the state enum `mem_seq_state_t`;
  - the constant `MMIO_ADDR`;
  - the default wait constants.
- Sub-module `mem_tristate` holds the `Mem_DQ` bidirectional buffer, controlled by a drive enable (high in WR and WR_REC only).

## Test plan
- **Default read:** Reset, then `Rd_req` with `Addr=0x00010` while SRAM returns 0x1234. Expect:
  - OE low for exactly 2 cycles;
  - `Done` and `Rd_data=0x1234` at n+3;
  - `Busy` high in n+1..n+2.
- **Default write:** `Wr_req` with `Addr=0x00020` and `Wr_data=0xBEEF`. Expect:
  - WE low for 2 cycles with DQ=0xBEEF;
  - DQ still driven in the hold cycle with WE high;
  - `Done` at n+4.
- **Simultaneous requests:** `Rd_req` and `Wr_req` high together, then `Addr` changed while `Busy`. Expect:
  - a write to the originally latched address;
  - no OE assertion;
  - `Rd_data` unchanged.
- **Reset mid-write:** `Reset_n` asserted during WR. Expect:
  - WE and CE high in the same cycle;
  - DQ tri-stated;
  - no `Done`;
  - a subsequent read works normally.
- **MMIO (with `MMIO_EN`):** write 0x00AB to 0xFFFF, then read 0xFFFF with `Switches=0x5A5A`. Expect:
  - `Hex_out=0x00AB`;
  - `Rd_data=0x5A5A`;
  - each `Done` at n+1;
  - no SRAM strobes.
- **Back-to-back with `RD_WAIT=0`:** a read request held continuously. Expect:
  - `Done` every 2 cycles;
  - the new access accepted in each `Done` cycle.
